// File: rtl/nanorv32_inst_stage_if.sv
// nanorv32_inst_stage_if: signal bundle between prefetch buffer, execute/IRQ control and decode for the instruction stage
//   slave  : the instruction stage (consumes buffer head + control, drives pop and the decode register)
//   master : the surrounding pipeline (drives buffer head + control, observes pop and the decode register)
`timescale 1ns/1ps
interface nanorv32_inst_stage_if #(parameter int INSTRET_W = 64);
    logic [31:0]          inst_i;
    logic                 is_32_i;
    logic                 fifo_empty_i;
    logic                 reset_over_i;
    logic                 force_stall_reset;
    logic                 stall_i;
    logic                 branch_taken_i;
    logic [31:0]          branch_target_i;
    logic                 irq_bypass_i;
    logic [31:0]          bypass_inst_i;
    logic                 pop_o;
    logic [31:0]          inst_o;
    logic                 inst_is_32_o;
    logic                 inst_valid_o;
    logic [31:0]          pc_o;
    logic [31:0]          pc_next_o;
    logic                 misaligned_o;
    logic [INSTRET_W-1:0] instret_o;
    modport slave(
        input  inst_i, is_32_i, fifo_empty_i, reset_over_i, force_stall_reset, stall_i,
               branch_taken_i, branch_target_i, irq_bypass_i, bypass_inst_i,
        output pop_o, inst_o, inst_is_32_o, inst_valid_o, pc_o, pc_next_o, misaligned_o, instret_o
    );
    modport master(
        output inst_i, is_32_i, fifo_empty_i, reset_over_i, force_stall_reset, stall_i,
               branch_taken_i, branch_target_i, irq_bypass_i, bypass_inst_i,
        input  pop_o, inst_o, inst_is_32_o, inst_valid_o, pc_o, pc_next_o, misaligned_o, instret_o
    );
endinterface

// File: rtl/nanorv32_inst_stage.sv
// nanorv32_inst_stage: fetch-to-decode register with PC sequencing, retire counter and IRQ bypass
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of nanorv32_inst_stage_if (buffer head in, pop out, decode register out)
`timescale 1ns/1ps
module nanorv32_inst_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013,
    parameter int          INSTRET_W = 64
) (
    input logic clk,
    input logic rst_n,
    nanorv32_inst_stage_if.slave bus
);
    typedef enum logic [1:0] {START, RUN, REDIR, BYP} state_t;
    state_t               state_q, state_d;
    logic [31:0]          inst_q, inst_d, pc_q, pc_d, pc_next_q, pc_next_d;
    logic                 is_32_q, is_32_d, valid_q, valid_d, first_run_q, first_run_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic                 adv, take, redirect;
    assign adv      = ~bus.stall_i & ~bus.force_stall_reset;
    assign redirect = bus.branch_taken_i & (state_q != START);
    assign take     = (state_q == RUN) & adv & ~bus.fifo_empty_i & ~bus.branch_taken_i & ~bus.irq_bypass_i;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= START;
            inst_q      <= NOP_INST;
            is_32_q     <= 1'b1;
            valid_q     <= 1'b0;
            pc_q        <= RESET_PC;
            pc_next_q   <= RESET_PC;
            first_run_q <= 1'b0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            inst_q      <= inst_d;
            is_32_q     <= is_32_d;
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            pc_next_q   <= pc_next_d;
            first_run_q <= first_run_d;
            instret_q   <= instret_d;
        end
    end
    // REDIR always lasts exactly one cycle, even under stall, so the refill bubble is fixed
    always_comb begin
        state_d = state_q;
        if (bus.force_stall_reset) state_d = START;
        else if (redirect) state_d = REDIR;
        else if (state_q == REDIR) state_d = RUN;
        else if (adv) state_d = (state_q == START) ? (bus.reset_over_i ? START : RUN) :
                                (state_q == RUN || state_q == BYP) ? (bus.irq_bypass_i ? BYP : RUN) : state_q;
    end
    always_comb begin
        inst_d    = inst_q;
        is_32_d   = is_32_q;
        valid_d   = valid_q;
        pc_d      = pc_q;
        pc_next_d = pc_next_q;
        if (bus.force_stall_reset) begin
            inst_d    = NOP_INST;
            valid_d   = 1'b0;
            pc_d      = RESET_PC;
            pc_next_d = RESET_PC;
        end else if (redirect) begin
            inst_d    = NOP_INST;
            valid_d   = 1'b0;
            pc_next_d = bus.branch_target_i & ~32'd1;
        end else if (take) begin
            inst_d    = bus.is_32_i ? bus.inst_i : {16'h0, bus.inst_i[15:0]};
            is_32_d   = bus.is_32_i;
            valid_d   = 1'b1;
            pc_d      = pc_next_q;
            pc_next_d = pc_next_q + (bus.is_32_i ? 32'd4 : 32'd2);
        end else if (adv && (state_q == BYP || (state_q == RUN && bus.irq_bypass_i))) begin
            // leaving BYP drops the injected instruction so it is neither re-issued nor counted
            inst_d  = bus.irq_bypass_i ? bus.bypass_inst_i : NOP_INST;
            is_32_d = bus.irq_bypass_i ? 1'b1 : is_32_q;
            valid_d = bus.irq_bypass_i;
        end else if (adv && state_q == RUN && bus.fifo_empty_i) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end
        first_run_d = (state_q == REDIR) & (state_d == RUN);
        instret_d   = instret_q + INSTRET_W'(valid_q & adv & ~bus.branch_taken_i & (state_q != BYP));
    end
    assign bus.pop_o        = take;
    assign bus.inst_o       = inst_q;
    assign bus.inst_is_32_o = is_32_q;
    assign bus.inst_valid_o = valid_q;
    assign bus.pc_o         = pc_q;
    assign bus.pc_next_o    = pc_next_q;
    assign bus.misaligned_o = first_run_q & pc_next_q[1] & bus.is_32_i;
    assign bus.instret_o    = instret_q;
endmodule

// File: doc/nanorv32_inst_stage.md
Name: nanorv32_inst_stage

Overview:
Fetch-to-decode pipeline register placed directly downstream of the prefetch buffer. Each cycle it takes the 16/32-bit instruction at the buffer head, registers it with its PC and a valid flag, and drives the pop/advance request back to the buffer. It owns the architectural PC sequencing: PC+2 for compressed, PC+4 for 32-bit, or a load on branch. It also counts retired instructions and handles the IRQ save/restore bypass that overrides the instruction register.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset and after force_stall_reset.
NOP_INST, 32'h0000_0013, instruction presented when inst_valid_o=0 (addi x0,x0,0).
INSTRET_W, 64, width of the retired-instruction counter.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active-low
inst_i  input  32  instruction at buffer head; upper half meaningful only when is_32_i=1
is_32_i  input  1  buffer-head instruction is 32-bit (inst_i[1:0]==2'b11)
fifo_empty_i  input  1  buffer has no complete instruction
reset_over_i  input  1  prefetch still in post-reset start-up
force_stall_reset  input  1  synchronous soft reset / stall
stall_i  input  1  downstream (execute) stall; hold the register
branch_taken_i  input  1  execute redirects the PC
branch_target_i  input  32  redirect target; bit0 ignored
irq_bypass_i  input  1  IRQ sequencer overrides the instruction register
bypass_inst_i  input  32  instruction injected during bypass
pop_o  output  1  buffer head consumed this cycle
inst_o  output  32  registered instruction to decode
inst_is_32_o  output  1  registered size flag
inst_valid_o  output  1  inst_o holds a real instruction
pc_o  output  32  PC of inst_o
pc_next_o  output  32  PC of the next instruction to be taken (to prefetch pc_next)
misaligned_o  output  1  branch_target_i[1] set and target at buffer head is 32-bit (informational, 1 cycle)
instret_o  output  INSTRET_W  count of retired instructions

Behaviour:
- Reset values: inst_o=NOP_INST, inst_valid_o=0, inst_is_32_o=1, pc_o=RESET_PC, pc_next_o=RESET_PC, pop_o=0, misaligned_o=0, instret_o=0, state=START.
- States:
  - START: leave when reset_over_i=0 → RUN. No pops while in START.
  - RUN: normal operation.
  - REDIR: one bubble after a branch while the prefetch refills.
  - BYP: IRQ bypass active.
- adv = ~stall_i & ~force_stall_reset. take = (state==RUN) & adv & ~fifo_empty_i & ~branch_taken_i & ~irq_bypass_i.
- pop_o = take (combinational, same cycle).
- On take:
  - inst_o <= is_32_i ? inst_i : {16'h0, inst_i[15:0]}; inst_is_32_o <= is_32_i; inst_valid_o <= 1.
  - pc_o <= pc_next_o; pc_next_o <= pc_next_o + (is_32_i ? 4 : 2), mod 2^32 wrap.
- RUN & adv & fifo_empty_i: inst_valid_o <= 0, inst_o <= NOP_INST; PCs unchanged.
- stall_i=1: all registers hold. branch_taken_i is still honoured, because execute owns the redirect.
- branch_taken_i, from any state except START:
  - pc_next_o <= {branch_target_i[31:1],1'b0}; inst_valid_o <= 0; state <= REDIR.
  - No pop that cycle. Branch has priority over take and irq_bypass_i.
- REDIR → RUN after exactly 1 cycle. misaligned_o pulses in the first RUN cycle when pc_next_o[1]=1 and is_32_i=1.
- irq_bypass_i=1 in RUN: state <= BYP, inst_o <= bypass_inst_i, inst_valid_o <= 1, inst_is_32_o <= 1. PCs frozen, no pop.
- In BYP: inst_o follows bypass_inst_i each non-stalled cycle. irq_bypass_i=0 → RUN.
- instret_o increments by 1 on every cycle with inst_valid_o=1 & adv & ~branch_taken_i. Bypass instructions are not counted. Wraps at 2^INSTRET_W.
- force_stall_reset=1 (overrides everything except rst_n):
  - state <= START, inst_valid_o <= 0, pc_next_o <= RESET_PC, pc_o <= RESET_PC.
  - instret_o is kept.
- Asynchronous rst_n mid-operation: all outputs return to their reset values immediately.

Test Plan:
- Reset release, reset_over_i held 3 cycles, then a stream of 32-bit 0x00500093 → no pop_o during START; first valid inst_o with pc_o=0x0, then pc_o 0x4, 0x8; instret_o=2 after the third.
- Mixed stream: C 0x4501, 32-bit 0x00A00113, C 0x0505 from 0x100 → pc_o 0x100, 0x102, 0x106; inst_o=0x00004501 with inst_is_32_o=0 for the compressed ones.
- fifo_empty_i=1 for 2 cycles mid-stream → inst_valid_o=0, inst_o=0x00000013, pc_next_o unchanged, instret_o frozen.
- branch_taken_i with target 0x202 while stall_i=1 and fifo non-empty → pop_o=0, one REDIR bubble, next pc_o=0x202; a 32-bit head raises misaligned_o for 1 cycle.
- irq_bypass_i for 3 cycles with bypass_inst_i=0x00112023 → inst_o=0x00112023, PCs frozen, instret_o unchanged, no pops; resume at the saved pc_next_o.
- force_stall_reset pulse at pc_o=0x40 with instret_o=17 → pc_o=pc_next_o=RESET_PC, state START, instret_o stays 17; rst_n low mid-stream → all outputs at reset values asynchronously.
